clock_hms: RTL and testbench
============================

// Module: clock_hms
// PURPOSE
//  Time-of-day counter (hh:mm:ss, BCD) downstream of the 50 MHz -> 1 Hz divider.
//  Runs on clk50 and consumes the divider's 1-cycle terminal-count pulse as an enable.
//  It does not use the divided clock output.
//  Two push-buttons set hours and minutes through a 3-state mode FSM.
//  BCD digits drive the 7-segment decoder stage.
// PARAMETERS
//  HOURS   24  hour format: 24 -> 00..23; 12 -> 01..12 with pm flag; other values illegal
// PORTS
//  clk        in   1  50 MHz system clock; all flops on posedge
//  reset      in   1  asynchronous, active-high; clears every register immediately
//  tick       in   1  1-cycle enable pulse, once per second (divider tc)
//  mode_btn   in   1  raw async level, debounced externally; rising edge = advance mode
//  inc_btn    in   1  raw async level, debounced externally; rising edge = +1 selected field
//  sec_lo/hi  out  4  seconds BCD digits (hi 0..5)
//  min_lo/hi  out  4  minutes BCD digits (hi 0..5)
//  hr_lo/hi   out  4  hours BCD digits
//  mode       out  2  00 RUN, 01 SET_HR, 10 SET_MIN (11 unused)
//  blink      out  1  toggles on every tick in all modes; display blanks the selected field when 1
//  pm         out  1  12h only: 1 = PM; constant 0 when HOURS=24
//  day_pulse  out  1  1-cycle high on day rollover
// BEHAVIOUR
//  Reset values:
//   - Time 00:00:00 (HOURS=24) or 12:00:00 (HOURS=12).
//   - mode=RUN; blink=0; pm=0; day_pulse=0.
//   - Synchroniser flops=0.
//  Buttons:
//   - Each button passes through a 2-flop synchroniser and a previous-value flop.
//   - pulse = sync2 & ~prev.
//   - Action takes effect on the 3rd posedge after the raw rise.
//   - A held button gives exactly one pulse.
//  FSM, on mode pulse: RUN->SET_HR->SET_MIN->RUN. Illegal state 11 -> RUN.
//  RUN:
//   - On tick, all outputs update at that same posedge (registered; 1-cycle latency from the tick cycle).
//   - Seconds carry into minutes; minutes carry into hours.
//   - 24h: 23:59:59 -> 00:00:00 with day_pulse=1 for exactly that one cycle.
//   - 12h: 11:59:59 -> 12:00:00 toggles pm; day_pulse fires only on PM->AM.
//   - 12h: 12:59:59 -> 01:00:00, no pm change.
//  SET_HR / SET_MIN:
//   - tick is ignored for counting; blink still toggles.
//   - An inc pulse adds 1 to the selected field only: no carry, no day_pulse, no pm change.
//   - Hours wrap 23->00 (24h) or 12->01 (12h). Minutes wrap 59->00.
//  Exiting SET_MIN->RUN clears seconds to 00.
//  inc pulses in RUN are ignored.
//  Simultaneous events: state and counter updates are both computed from the current (pre-edge) state.
//   - tick + mode pulse in RUN: the tick increment is applied AND mode goes to SET_HR at the same edge.
//   - inc + mode pulse in SET_HR: hours increment and mode goes to SET_MIN.
//  Arithmetic:
//   - Per-digit BCD with explicit compare-and-clear; never binary-then-convert.
//   - Digits never leave their legal range.
//  Reset mid-set: returns immediately to RUN with reset time values.
// TESTING
//  T1: reset, 60 ticks (spaced >=4 clk) -> 00:01:00; 3600 ticks total -> 01:00:00; day_pulse never set.
//  T2: set to 23:59 (mode, 23 inc, mode, 59 inc, mode), 59 ticks -> 23:59:59.
//      Next tick -> 00:00:00, day_pulse high exactly 1 cycle.
//  T3: SET_MIN at 00:59, 1 inc -> 00:00 (hours unchanged); 10 ticks in SET mode -> time frozen, blink toggled 10x.
//  T4: RUN at 00:00:30, tick and mode pulse on same cycle -> 00:00:31 and mode=01.
//      Exit SET_MIN -> seconds=00.
//  T5: assert reset while in SET_MIN at 07:42 -> async clear to RUN 00:00:00 with no clk edge needed.
//      Held inc_btn for 1000 cycles gives one increment.
//  T6: HOURS=12: reset -> 12:00:00 pm=0; set 11:59, run to 11:59:59, tick -> 12:00:00 pm=1.
//      From 12:59:59, tick -> 01:00:00 pm=1.

Source files
------------

// File: rtl/clock_hms.sv
// clock_hms: BCD hh:mm:ss time-of-day counter, advanced by the 1 Hz divider enable.
// Two synchronised push-buttons select and increment the hour/minute fields.
module clock_hms #(
   parameter int HOURS = 24
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       mode_btn,
   input  logic       inc_btn,
   output logic [3:0] sec_lo,
   output logic [3:0] sec_hi,
   output logic [3:0] min_lo,
   output logic [3:0] min_hi,
   output logic [3:0] hr_lo,
   output logic [3:0] hr_hi,
   output logic [1:0] mode,
   output logic       blink,
   output logic       pm,
   output logic       day_pulse
);

   // Only HOURS of 12 or 24 are meaningful; anything other than 12 behaves as 24.
   localparam bit         IS_12H   = (HOURS == 12);
   localparam logic [7:0] HR_RESET = IS_12H ? 8'h12 : 8'h00;
   localparam logic [7:0] HR_MAX   = IS_12H ? 8'h12 : 8'h23;
   localparam logic [7:0] HR_WRAP  = IS_12H ? 8'h01 : 8'h00;

   typedef enum logic [1:0] {
      RUN     = 2'b00,
      SET_HR  = 2'b01,
      SET_MIN = 2'b10
   } mode_t;

   mode_t      state;
   mode_t      state_nx;
   logic [2:0] mode_sync;
   logic [2:0] inc_sync;
   logic       mode_pulse;
   logic       inc_pulse;
   logic [7:0] sec;
   logic [7:0] min;
   logic [7:0] hr;
   logic [7:0] sec_nx;
   logic [7:0] min_nx;
   logic [7:0] hr_nx;
   logic       pm_nx;
   logic       blink_nx;
   logic       day_nx;
   logic       sec_carry;
   logic       min_carry;

   function automatic logic [7:0] inc_sexa(input logic [7:0] v);
      logic [7:0] r;
      if (v[3:0] == 4'd9) begin
         if (v[7:4] == 4'd5) begin
            r = 8'h00;
         end else begin
            r = {v[7:4] + 4'd1, 4'd0};
         end
      end else begin
         r = {v[7:4], v[3:0] + 4'd1};
      end
      return r;
   endfunction

   function automatic logic [7:0] inc_hour(input logic [7:0] v);
      logic [7:0] r;
      if (v == HR_MAX) begin
         r = HR_WRAP;
      end else if (v[3:0] == 4'd9) begin
         r = {v[7:4] + 4'd1, 4'd0};
      end else begin
         r = {v[7:4], v[3:0] + 4'd1};
      end
      return r;
   endfunction

   // Button synchronisers: [0] first stage, [1] second stage, [2] previous value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_sync <= 3'b000;
         inc_sync  <= 3'b000;
      end else begin
         mode_sync <= {mode_sync[1:0], mode_btn};
         inc_sync  <= {inc_sync[1:0], inc_btn};
      end
   end

   assign mode_pulse = mode_sync[1] & ~mode_sync[2];
   assign inc_pulse  = inc_sync[1] & ~inc_sync[2];

   // Mode state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= RUN;
      end else begin
         state <= state_nx;
      end
   end

   // Mode sequencing RUN -> SET_HR -> SET_MIN -> RUN; the unused code recovers to RUN.
   always_comb begin
      state_nx = state;
      case (state)
         RUN:     state_nx = mode_pulse ? SET_HR : RUN;
         SET_HR:  state_nx = mode_pulse ? SET_MIN : SET_HR;
         SET_MIN: state_nx = mode_pulse ? RUN : SET_MIN;
         default: state_nx = RUN;
      endcase
   end

   assign sec_carry = (sec == 8'h59);
   assign min_carry = sec_carry & (min == 8'h59);

   // Next time value; every field is derived from the pre-edge state.
   always_comb begin
      sec_nx   = sec;
      min_nx   = min;
      hr_nx    = hr;
      pm_nx    = pm;
      day_nx   = 1'b0;
      blink_nx = blink ^ tick;
      case (state)
         RUN: begin
            if (tick) begin
               sec_nx = inc_sexa(sec);
               min_nx = sec_carry ? inc_sexa(min) : min;
               hr_nx  = min_carry ? inc_hour(hr) : hr;
               // In 12h mode 11:59:59 flips AM/PM; only the PM->AM flip is a new day.
               if (IS_12H) begin
                  pm_nx  = (min_carry && (hr == 8'h11)) ? ~pm : pm;
                  day_nx = min_carry && (hr == 8'h11) && pm;
               end else begin
                  pm_nx  = 1'b0;
                  day_nx = min_carry && (hr == 8'h23);
               end
            end else begin
               day_nx = 1'b0;
            end
         end
         SET_HR: begin
            if (inc_pulse) begin
               hr_nx = inc_hour(hr);
            end else begin
               hr_nx = hr;
            end
         end
         SET_MIN: begin
            min_nx = inc_pulse ? inc_sexa(min) : min;
            sec_nx = mode_pulse ? 8'h00 : sec;
         end
         default: begin
            sec_nx = sec;
         end
      endcase
   end

   // Time, flag and blink registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sec       <= 8'h00;
         min       <= 8'h00;
         hr        <= HR_RESET;
         pm        <= 1'b0;
         blink     <= 1'b0;
         day_pulse <= 1'b0;
      end else begin
         sec       <= sec_nx;
         min       <= min_nx;
         hr        <= hr_nx;
         pm        <= pm_nx;
         blink     <= blink_nx;
         day_pulse <= day_nx;
      end
   end

   assign sec_lo = sec[3:0];
   assign sec_hi = sec[7:4];
   assign min_lo = min[3:0];
   assign min_hi = min[7:4];
   assign hr_lo  = hr[3:0];
   assign hr_hi  = hr[7:4];
   assign mode   = state;

endmodule

// File: tb/tb_clock_hms.sv
// tb_clock_hms: drives a 24h and a 12h clock_hms with shared stimulus and checks both
// every cycle against a seconds-of-day reference model, plus directed vectors.
module tb_clock_hms;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic tick = 1'b0;
   logic mode_btn = 1'b0;
   logic inc_btn = 1'b0;

   logic [3:0] sl24, sh24, ml24, mh24, hl24, hh24;
   logic [1:0] md24;
   logic       bl24, pm24, dp24;
   logic [3:0] sl12, sh12, ml12, mh12, hl12, hh12;
   logic [1:0] md12;
   logic       bl12, pm12, dp12;

   always #10 clk = ~clk;

   clock_hms #(.HOURS(24)) dut24 (
      .clk(clk), .reset(reset), .tick(tick), .mode_btn(mode_btn), .inc_btn(inc_btn),
      .sec_lo(sl24), .sec_hi(sh24), .min_lo(ml24), .min_hi(mh24), .hr_lo(hl24), .hr_hi(hh24),
      .mode(md24), .blink(bl24), .pm(pm24), .day_pulse(dp24)
   );

   clock_hms #(.HOURS(12)) dut12 (
      .clk(clk), .reset(reset), .tick(tick), .mode_btn(mode_btn), .inc_btn(inc_btn),
      .sec_lo(sl12), .sec_hi(sh12), .min_lo(ml12), .min_hi(mh12), .hr_lo(hl12), .hr_hi(hh12),
      .mode(md12), .blink(bl12), .pm(pm12), .day_pulse(dp12)
   );

   typedef struct {
      bit        tk;
      bit        mb;
      bit        ib;
      bit [23:0] hms;
      bit [1:0]  md;
      bit        bl;
   } vec_t;

   vec_t tbl [14];

   int checks = 0;
   int errors = 0;

   // Reference model: time as seconds since midnight, mode as 0/1/2, raw button history.
   int     t24, t12, md_m;
   bit     bl_m, dp24_m, dp12_m;
   bit [3:0] mh, ih;
   bit     seen_dp;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [28:0] exp_vec(input int t, input bit twelve, input int md,
                                           input bit bl, input bit dp);
      int h, m, s, hd;
      bit p;
      h = t / 3600;
      m = (t / 60) % 60;
      s = t % 60;
      if (twelve) begin
         hd = (h % 12 == 0) ? 12 : h % 12;
         p  = (h >= 12);
      end else begin
         hd = h;
         p  = 1'b0;
      end
      return {4'(hd / 10), 4'(hd % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
              2'(md), bl, p, dp};
   endfunction

   function automatic int inc_hr24(input int t);
      return ((t / 3600 + 1) % 24) * 3600 + t % 3600;
   endfunction

   function automatic int inc_hr12(input int t);
      int h24, d, d2, nh;
      h24 = t / 3600;
      d   = (h24 % 12 == 0) ? 12 : h24 % 12;
      d2  = (d == 12) ? 1 : d + 1;
      nh  = (d2 % 12) + ((h24 >= 12) ? 12 : 0);
      return nh * 3600 + t % 3600;
   endfunction

   function automatic int inc_min(input int t);
      int m;
      m = (t / 60) % 60;
      return t - m * 60 + ((m + 1) % 60) * 60;
   endfunction

   function automatic void model_reset();
      t24 = 0; t12 = 0; md_m = 0;
      bl_m = 1'b0; dp24_m = 1'b0; dp12_m = 1'b0;
      mh = 4'b0000; ih = 4'b0000;
   endfunction

   // A button level first present at edge e-2 (and absent at e-3) acts at edge e.
   function automatic void model_edge(input bit tk, input bit mb, input bit ib);
      bit mp, ip;
      mh = {mh[2:0], mb};
      ih = {ih[2:0], ib};
      mp = mh[2] & ~mh[3];
      ip = ih[2] & ~ih[3];
      dp24_m = 1'b0;
      dp12_m = 1'b0;
      case (md_m)
         0: begin
            if (tk) begin
               t24 = (t24 + 1) % 86400;
               t12 = (t12 + 1) % 86400;
               dp24_m = (t24 == 0);
               dp12_m = (t12 == 0);
            end
            if (mp) md_m = 1;
         end
         1: begin
            if (ip) begin
               t24 = inc_hr24(t24);
               t12 = inc_hr12(t12);
            end
            if (mp) md_m = 2;
         end
         default: begin
            if (ip) begin
               t24 = inc_min(t24);
               t12 = inc_min(t12);
            end
            if (mp) begin
               md_m = 0;
               t24 = t24 - t24 % 60;
               t12 = t12 - t12 % 60;
            end
         end
      endcase
      if (tk) bl_m = ~bl_m;
   endfunction

   task automatic compare_all();
      check("model24", 32'({hh24, hl24, mh24, ml24, sh24, sl24, md24, bl24, pm24, dp24}),
            32'(exp_vec(t24, 1'b0, md_m, bl_m, dp24_m)));
      check("model12", 32'({hh12, hl12, mh12, ml12, sh12, sl12, md12, bl12, pm12, dp12}),
            32'(exp_vec(t12, 1'b1, md_m, bl_m, dp12_m)));
   endtask

   task automatic step(input bit tk, input bit mb, input bit ib);
      tick = tk;
      mode_btn = mb;
      inc_btn = ib;
      @(posedge clk);
      model_edge(tk, mb, ib);
      @(negedge clk);
      compare_all();
      seen_dp |= dp24;
   endtask

   task automatic expect_hms(input string name, input bit twelve, input logic [23:0] hms,
                             input logic [1:0] md);
      if (twelve)
         check(name, 32'({hh12, hl12, mh12, ml12, sh12, sl12, md12}), 32'({hms, md}));
      else
         check(name, 32'({hh24, hl24, mh24, ml24, sh24, sl24, md24}), 32'({hms, md}));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick = 1'b0;
      mode_btn = 1'b0;
      inc_btn = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      compare_all();
   endtask

   task automatic press_mode();
      repeat (3) step(1'b0, 1'b1, 1'b0);
      repeat (2) step(1'b0, 1'b0, 1'b0);
   endtask

   task automatic press_inc(input int n);
      repeat (n) begin
         repeat (3) step(1'b0, 1'b0, 1'b1);
         repeat (2) step(1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic ticks(input int n, input int gap);
      repeat (n) begin
         step(1'b1, 1'b0, 1'b0);
         repeat (gap) step(1'b0, 1'b0, 1'b0);
      end
   endtask

   initial begin
      int tg;
      logic prev_bl;
      bit mb_l, ib_l;

      tbl[0]  = '{1'b1, 1'b0, 1'b0, 24'h000001, 2'd0, 1'b1};
      tbl[1]  = '{1'b0, 1'b1, 1'b0, 24'h000001, 2'd0, 1'b1};
      tbl[2]  = '{1'b0, 1'b1, 1'b0, 24'h000001, 2'd0, 1'b1};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, 24'h000001, 2'd1, 1'b1};
      tbl[4]  = '{1'b1, 1'b1, 1'b1, 24'h000001, 2'd1, 1'b0};
      tbl[5]  = '{1'b0, 1'b0, 1'b1, 24'h000001, 2'd1, 1'b0};
      tbl[6]  = '{1'b0, 1'b0, 1'b1, 24'h010001, 2'd1, 1'b0};
      tbl[7]  = '{1'b1, 1'b0, 1'b0, 24'h010001, 2'd1, 1'b1};
      tbl[8]  = '{1'b0, 1'b1, 1'b0, 24'h010001, 2'd1, 1'b1};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 24'h010001, 2'd1, 1'b1};
      tbl[10] = '{1'b0, 1'b1, 1'b1, 24'h010001, 2'd2, 1'b1};
      tbl[11] = '{1'b0, 1'b0, 1'b0, 24'h010001, 2'd2, 1'b1};
      tbl[12] = '{1'b0, 1'b0, 1'b0, 24'h010100, 2'd0, 1'b1};
      tbl[13] = '{1'b1, 1'b0, 1'b0, 24'h010101, 2'd0, 1'b0};

      model_reset();
      seen_dp = 1'b0;

      do_reset();
      expect_hms("reset24", 1'b0, 24'h000000, 2'd0);
      expect_hms("reset12", 1'b1, 24'h120000, 2'd0);
      check("reset_flags", 32'({bl24, pm24, dp24, bl12, pm12, dp12}), 32'(0));

      for (int k = 0; k < 14; k++) begin
         step(tbl[k].tk, tbl[k].mb, tbl[k].ib);
         check($sformatf("vec%0d", k),
               32'({hh24, hl24, mh24, ml24, sh24, sl24, md24, bl24}),
               32'({tbl[k].hms, tbl[k].md, tbl[k].bl}));
      end

      // Plain running: minutes and hours carry, no day rollover.
      do_reset();
      seen_dp = 1'b0;
      ticks(60, 3);
      expect_hms("t1_1min", 1'b0, 24'h000100, 2'd0);
      ticks(3540, 3);
      expect_hms("t1_1hr", 1'b0, 24'h010000, 2'd0);
      check("t1_no_day", 32'(seen_dp), 32'(0));

      // Set 23:59 (11:59 AM on the 12h unit), then roll over midnight / noon.
      do_reset();
      press_mode();
      press_inc(23);
      press_mode();
      press_inc(59);
      press_mode();
      expect_hms("t2_set", 1'b0, 24'h235900, 2'd0);
      expect_hms("t6_set", 1'b1, 24'h115900, 2'd0);
      ticks(59, 3);
      expect_hms("t2_59s", 1'b0, 24'h235959, 2'd0);
      step(1'b1, 1'b0, 1'b0);
      expect_hms("t2_wrap", 1'b0, 24'h000000, 2'd0);
      check("t2_day_hi", 32'(dp24), 32'(1));
      expect_hms("t6_noon", 1'b1, 24'h120000, 2'd0);
      check("t6_pm_noon", 32'({pm12, dp12}), 32'(2));
      step(1'b0, 1'b0, 1'b0);
      check("t2_day_lo", 32'(dp24), 32'(0));
      ticks(3599, 1);
      expect_hms("t6_1259", 1'b1, 24'h125959, 2'd0);
      step(1'b1, 1'b0, 1'b0);
      expect_hms("t6_one", 1'b1, 24'h010000, 2'd0);
      check("t6_pm_one", 32'(pm12), 32'(1));

      // Minutes wrap without carry; ticks freeze time in set mode while blink runs.
      do_reset();
      press_mode();
      press_mode();
      press_inc(59);
      expect_hms("t3_0059", 1'b0, 24'h005900, 2'd2);
      press_inc(1);
      expect_hms("t3_wrap", 1'b0, 24'h000000, 2'd2);
      tg = 0;
      repeat (10) begin
         prev_bl = bl24;
         step(1'b1, 1'b0, 1'b0);
         if (bl24 != prev_bl) tg++;
         step(1'b0, 1'b0, 1'b0);
      end
      expect_hms("t3_frozen", 1'b0, 24'h000000, 2'd2);
      check("t3_blinks", 32'(tg), 32'(10));
      press_mode();

      // Tick and mode pulse on the same edge, then exit clears seconds.
      ticks(30, 3);
      expect_hms("t4_30s", 1'b0, 24'h000030, 2'd0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      expect_hms("t4_both", 1'b0, 24'h000031, 2'd1);
      step(1'b0, 1'b0, 1'b0);
      press_mode();
      press_mode();
      expect_hms("t4_exit", 1'b0, 24'h000000, 2'd0);

      // Asynchronous reset while setting, then a long-held inc button.
      press_mode();
      press_inc(7);
      press_mode();
      press_inc(42);
      expect_hms("t5_0742", 1'b0, 24'h074200, 2'd2);
      reset = 1'b1;
      #2;
      model_reset();
      expect_hms("t5_async", 1'b0, 24'h000000, 2'd0);
      compare_all();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      compare_all();
      press_mode();
      repeat (1000) step(1'b0, 1'b0, 1'b1);
      repeat (2) step(1'b0, 1'b0, 1'b0);
      expect_hms("t5_held", 1'b0, 24'h010000, 2'd1);
      press_mode();
      press_mode();

      // Random buttons and ticks against the model.
      do_reset();
      mb_l = 1'b0;
      ib_l = 1'b0;
      repeat (4000) begin
         if ($urandom_range(0, 5) == 0) mb_l = ~mb_l;
         if ($urandom_range(0, 4) == 0) ib_l = ~ib_l;
         step($urandom_range(0, 2) == 0, mb_l, ib_l);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
